// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Synchronises a raw push-button and debounces it. The output
//                is a clean level plus one-clock rise and fall pulses.
//  Revision    : 1.0
// ============================================================================
module btn_debounce #(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic db_level,
    output logic db_rise,
    output logic db_fall
);

    localparam int              CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_ZERO  = 2'd0,
        ST_WAIT1 = 2'd1,
        ST_ONE   = 2'd2,
        ST_WAIT0 = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Only the last synchroniser stage may be seen by the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign btn_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_ZERO: begin
                if (btn_s) begin
                    state_d = ST_WAIT1;
                    cnt_d   = '0;
                end
            end
            ST_WAIT1: begin
                if (!btn_s) begin
                    state_d = ST_ZERO;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_ONE;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_ONE: begin
                if (!btn_s) begin
                    state_d = ST_WAIT0;
                    cnt_d   = '0;
                end
            end
            ST_WAIT0: begin
                if (btn_s) begin
                    state_d = ST_ONE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_ZERO;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_ZERO;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ZERO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign db_level = level_q;
    assign db_rise  = rise_q;
    assign db_fall  = fall_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_debounce
//  Description : Self-checking bench for btn_debounce (DB_CYCLES=8, 2 stages).
//  Revision    : 1.0
// ============================================================================
module tb_btn_debounce;

    localparam int DB   = 8;
    localparam int SYNC = 2;

    logic clk;
    logic reset;
    logic btn_in;
    logic db_level;
    logic db_rise;
    logic db_fall;

    btn_debounce #(
        .DB_CYCLES   (DB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .db_level (db_level),
        .db_rise  (db_rise),
        .db_fall  (db_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: the FSM sees the pad value sampled SYNC edges earlier; a
    // change is accepted after DB+1 consecutive samples differing from level.
    int   m_dq[$];
    int   m_run;
    logic m_lvl, m_rise, m_fall;
    int   dut_pulses, mdl_pulses;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic mdl_clear();
        m_dq = {};
        for (int i = 0; i < SYNC; i++) m_dq.push_back(0);
        m_run  = 0;
        m_lvl  = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
    endtask

    task automatic mdl_edge(input logic b);
        int s;
        s = m_dq.pop_front();
        m_dq.push_back(int'(b));
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s != int'(m_lvl)) begin
            m_run++;
            if (m_run == DB + 1) begin
                m_lvl = ~m_lvl;
                if (m_lvl) m_rise = 1'b1;
                else       m_fall = 1'b1;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) mdl_clear();
        else       mdl_edge(btn_in);
        #1;
        chk("model", int'({db_level, db_rise, db_fall}), int'({m_lvl, m_rise, m_fall}));
        chk("exclusive", int'(db_rise & db_fall), 0);
        dut_pulses += int'(db_rise) + int'(db_fall);
        mdl_pulses += int'(m_rise) + int'(m_fall);
    endtask

    typedef struct {
        logic btn;
        int   hold;
        int   rise_at;
        int   fall_at;
        logic lvl;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int r_at, f_at, pulses, len;
        logic b;

        tbl[0]  = '{1'b0, 20, -1, 11, 1'b0};
        tbl[1]  = '{1'b1, 20, 11, -1, 1'b1};
        tbl[2]  = '{1'b0, 20, -1, 11, 1'b0};
        tbl[3]  = '{1'b1,  7, -1, -1, 1'b0};
        tbl[4]  = '{1'b0, 15, -1, -1, 1'b0};
        tbl[5]  = '{1'b1,  8, -1, -1, 1'b0};
        tbl[6]  = '{1'b0, 15, -1, -1, 1'b0};
        tbl[7]  = '{1'b1, 20, 11, -1, 1'b1};
        tbl[8]  = '{1'b0,  7, -1, -1, 1'b1};
        tbl[9]  = '{1'b1, 15, -1, -1, 1'b1};
        tbl[10] = '{1'b0,  8, -1, -1, 1'b1};
        tbl[11] = '{1'b1, 15, -1, -1, 1'b1};
        tbl[12] = '{1'b0, 20, -1, 11, 1'b0};
        tbl[13] = '{1'b1,  9, -1, -1, 1'b0};
        tbl[14] = '{1'b0, 20,  2, 11, 1'b0};

        dut_pulses = 0;
        mdl_pulses = 0;
        reset  = 1'b1;
        btn_in = 1'b1;
        mdl_clear();

        // Reset held with the button pressed.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_hold", int'({db_level, db_rise, db_fall}), 0);
        end

        @(negedge clk);
        reset = 1'b0;
        r_at  = -1;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (db_rise && r_at < 0) r_at = i;
            if (i == 12) chk("rise_one_clk", int'({db_level, db_rise}), 2);
        end
        chk("release_rise_at", r_at, 11);

        // Table of hold periods starting from level 1.
        for (int t = 0; t < 15; t++) begin
            btn_in = tbl[t].btn;
            r_at = -1;
            f_at = -1;
            for (int i = 1; i <= tbl[t].hold; i++) begin
                step();
                if (db_rise && r_at < 0) r_at = i;
                if (db_fall && f_at < 0) f_at = i;
            end
            chk($sformatf("tbl%0d_rise_at", t), r_at, tbl[t].rise_at);
            chk($sformatf("tbl%0d_fall_at", t), f_at, tbl[t].fall_at);
            chk($sformatf("tbl%0d_level", t), int'(db_level), int'(tbl[t].lvl));
        end

        // Bounce: 4 x (3 high, 2 low), then stays high.
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            btn_in = 1'b1;
            for (int i = 0; i < 3; i++) begin step(); pulses += int'(db_rise | db_fall); end
            btn_in = 1'b0;
            for (int i = 0; i < 2; i++) begin step(); pulses += int'(db_rise | db_fall); end
        end
        chk("bounce_no_pulse", pulses, 0);
        btn_in = 1'b1;
        r_at = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (db_rise && r_at < 0) r_at = i;
        end
        chk("bounce_rise_at", r_at, 11);
        chk("bounce_level", int'(db_level), 1);

        // Asynchronous reset while level is high.
        #2 reset = 1'b1;
        mdl_clear();
        #1 chk("async_clear", int'({db_level, db_rise, db_fall}), 0);
        @(negedge clk);
        reset = 1'b0;

        // Reset in WAIT1 with cnt=5, button still held.
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin step(); pulses += int'(db_rise); end
        chk("wait1_no_rise", pulses, 0);
        #2 reset = 1'b1;
        mdl_clear();
        #1 chk("wait1_reset", int'({db_level, db_rise, db_fall}), 0);
        step();
        step();
        @(negedge clk);
        reset = 1'b0;
        r_at = -1;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (db_rise && r_at < 0) r_at = i;
        end
        chk("wait1_reset_rise_at", r_at, 11);

        // Random runs against the reference model.
        dut_pulses = 0;
        mdl_pulses = 0;
        b = 1'b0;
        len = 0;
        for (int c = 0; c < 10000; c++) begin
            if (len == 0) begin
                b   = ~b;
                len = $urandom_range(1, 20);
            end
            btn_in = b;
            len--;
            step();
        end
        chk("random_pulse_count", dut_pulses, mdl_pulses);
        chk("random_pulses_seen", int'(mdl_pulses > 0), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
